// File: rtl/exe_stage_pkg.sv
// Shared MIPS32 definitions: ALU types, opcodes, exception codes,
// and divider FSM states.
package mips_defs_pkg;

   localparam logic [2:0] ALUTYPE_MULDIV = 3'b000;
   localparam logic [2:0] ALUTYPE_ARITH  = 3'b001;
   localparam logic [2:0] ALUTYPE_LOGIC  = 3'b010;
   localparam logic [2:0] ALUTYPE_MOVE   = 3'b011;
   localparam logic [2:0] ALUTYPE_SHIFT  = 3'b100;
   localparam logic [2:0] ALUTYPE_JUMP   = 3'b101;
   localparam logic [2:0] ALUTYPE_PRIV   = 3'b110;

   localparam logic [7:0] OP_LUI   = 8'h05;
   localparam logic [7:0] OP_MFHI  = 8'h0C;
   localparam logic [7:0] OP_MFLO  = 8'h0D;
   localparam logic [7:0] OP_SLL   = 8'h11;
   localparam logic [7:0] OP_MULT  = 8'h14;
   localparam logic [7:0] OP_DIV   = 8'h16;
   localparam logic [7:0] OP_ADD   = 8'h18;
   localparam logic [7:0] OP_ADDIU = 8'h19;
   localparam logic [7:0] OP_SUBU  = 8'h1B;
   localparam logic [7:0] OP_AND   = 8'h1C;
   localparam logic [7:0] OP_ORI   = 8'h1D;
   localparam logic [7:0] OP_SLT   = 8'h26;
   localparam logic [7:0] OP_SLTIU = 8'h27;
   localparam logic [7:0] OP_J     = 8'h2C;
   localparam logic [7:0] OP_JR    = 8'h2D;
   localparam logic [7:0] OP_JAL   = 8'h2E;
   localparam logic [7:0] OP_LB    = 8'h90;
   localparam logic [7:0] OP_LW    = 8'h92;
   localparam logic [7:0] OP_SB    = 8'h98;
   localparam logic [7:0] OP_SW    = 8'h9A;

   localparam logic [4:0] EXC_NONE = 5'h10;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_OV   = 5'h0C;
   localparam logic [4:0] EXC_ERET = 5'h11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE/MEM pipeline bundle seen by the execute stage.
interface exe_stage_if;
   logic [2:0]  exe_alutype_i;
   logic [7:0]  exe_aluop_i;
   logic [31:0] exe_src1_i;
   logic [31:0] exe_src2_i;
   logic [4:0]  exe_wa_i;
   logic        exe_wreg_i;
   logic        exe_mreg_i;
   logic        exe_whilo_i;
   logic [31:0] exe_din_i;
   logic [31:0] exe_ret_addr_i;
   logic [31:0] exe_pc_i;
   logic        exe_in_delay_i;
   logic [4:0]  exe_exccode_i;

   logic [31:0] exe_wd_o;
   logic [63:0] exe_hilo_o;
   logic [4:0]  exe_wa_o;
   logic        exe_wreg_o;
   logic        exe_mreg_o;
   logic        exe_whilo_o;
   logic [31:0] exe_din_o;
   logic [7:0]  exe_aluop_o;
   logic [31:0] exe_pc_o;
   logic        exe_in_delay_o;
   logic [4:0]  exe_exccode_o;

   modport master (
      output exe_alutype_i, exe_aluop_i, exe_src1_i, exe_src2_i,
             exe_wa_i, exe_wreg_i, exe_mreg_i, exe_whilo_i,
             exe_din_i, exe_ret_addr_i, exe_pc_i, exe_in_delay_i,
             exe_exccode_i,
      input  exe_wd_o, exe_hilo_o, exe_wa_o, exe_wreg_o,
             exe_mreg_o, exe_whilo_o, exe_din_o, exe_aluop_o,
             exe_pc_o, exe_in_delay_o, exe_exccode_o
   );

   modport slave (
      input  exe_alutype_i, exe_aluop_i, exe_src1_i, exe_src2_i,
             exe_wa_i, exe_wreg_i, exe_mreg_i, exe_whilo_i,
             exe_din_i, exe_ret_addr_i, exe_pc_i, exe_in_delay_i,
             exe_exccode_i,
      output exe_wd_o, exe_hilo_o, exe_wa_o, exe_wreg_o,
             exe_mreg_o, exe_whilo_o, exe_din_o, exe_aluop_o,
             exe_pc_o, exe_in_delay_o, exe_exccode_o
   );
endinterface

// File: rtl/exe_stage_div_iter.sv
// Iterative signed restoring divider, one quotient bit per cycle.
module div_iter #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic        i_flush,
   input  logic        i_hold,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_quo,
   output logic [31:0] o_rem
);
   import mips_defs_pkg::*;

   localparam int CW = $clog2(DIV_CYCLES) + 1;

   div_state_t  r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0] r_quo, r_rem, r_dvs;
   logic        r_neg_q, r_neg_r;
   logic [31:0] w_a, w_b;
   logic [32:0] w_sh, w_diff;
   logic        w_ge;

   assign w_a    = i_dividend[31] ? -i_dividend : i_dividend;
   assign w_b    = i_divisor[31] ? -i_divisor : i_divisor;
   assign w_sh   = {r_rem, r_quo[31]};
   assign w_diff = w_sh - {1'b0, r_dvs};
   assign w_ge   = ~w_diff[32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= DIV_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         DIV_IDLE:
            if (i_start)
               w_next = (i_divisor == '0) ? DIV_DONE : DIV_BUSY;
         DIV_BUSY:
            if (r_cnt == CW'(DIV_CYCLES - 1)) w_next = DIV_DONE;
         DIV_DONE:
            if (!i_hold) w_next = DIV_IDLE;
         default: w_next = DIV_IDLE;
      endcase
      if (i_flush) w_next = DIV_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == DIV_IDLE && w_next == DIV_BUSY) begin
         r_cnt   <= '0;
         r_quo   <= w_a;
         r_rem   <= '0;
         r_dvs   <= w_b;
         r_neg_q <= i_dividend[31] ^ i_divisor[31];
         r_neg_r <= i_dividend[31];
      end else if (r_state == DIV_IDLE && w_next == DIV_DONE) begin
         // divide by zero: LO all ones, HI keeps the raw dividend
         r_cnt   <= '0;
         r_quo   <= '1;
         r_rem   <= i_dividend;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == DIV_BUSY && !i_flush) begin
         r_rem <= w_ge ? w_diff[31:0] : w_sh[31:0];
         r_quo <= {r_quo[30:0], w_ge};
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_busy = i_start && (r_state != DIV_DONE) && !i_flush;
   assign o_done = (r_state == DIV_DONE);
   assign o_quo  = r_neg_q ? -r_quo : r_quo;
   assign o_rem  = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: ALU, HI/LO forwarding, exception merge.
// Define EXE_DIV_EN to build in the iterative signed divider.
module exe_stage #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        cpu_clk,
   input  logic        rst_n,
   exe_stage_if.slave  ex,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        mem2exe_whilo,
   input  logic [63:0] mem2exe_hilo,
   input  logic        wb2exe_whilo,
   input  logic [63:0] wb2exe_hilo,
   input  logic        exe_hold,
   input  logic        flush,
   output logic        exe2id_wreg,
   output logic [4:0]  exe2id_wa,
   output logic [31:0] exe2id_wd,
   output logic        exe2id_mreg,
   output logic        stallreq_exe
);
   import mips_defs_pkg::*;

   logic [31:0] w_a, w_b, w_sum, w_diff, w_hi, w_lo, w_wd;
   logic [63:0] w_prod, w_hilo, w_div_hilo;
   logic [7:0]  w_op;
   logic        w_ov, w_exc_ov, w_is_div, w_is_mult, w_busy;
   logic        w_wreg;

   assign w_a    = ex.exe_src1_i;
   assign w_b    = ex.exe_src2_i;
   assign w_op   = ex.exe_aluop_i;
   assign w_sum  = w_a + w_b;
   assign w_diff = w_a - w_b;
   assign w_prod = $signed({{32{w_a[31]}}, w_a}) *
                   $signed({{32{w_b[31]}}, w_b});

   assign w_ov = (w_op == OP_ADD) && (w_a[31] == w_b[31]) &&
                 (w_sum[31] != w_a[31]);
   // an exception already raised upstream takes precedence
   assign w_exc_ov = w_ov && (ex.exe_exccode_i == EXC_NONE);

   assign w_is_mult = (ex.exe_alutype_i == ALUTYPE_MULDIV) &&
                      (w_op == OP_MULT);
   assign w_is_div  = (ex.exe_alutype_i == ALUTYPE_MULDIV) &&
                      (w_op == OP_DIV);

   always_comb begin
      w_hi = hi_i;
      w_lo = lo_i;
      if (mem2exe_whilo) begin
         w_hi = mem2exe_hilo[63:32];
         w_lo = mem2exe_hilo[31:0];
      end else if (wb2exe_whilo) begin
         w_hi = wb2exe_hilo[63:32];
         w_lo = wb2exe_hilo[31:0];
      end
   end

   always_comb begin
      w_wd = '0;
      unique case (1'b1)
         (ex.exe_alutype_i == ALUTYPE_ARITH):
            case (w_op)
               OP_ADD, OP_ADDIU, OP_LB, OP_LW, OP_SB, OP_SW:
                  w_wd = w_sum;
               OP_SUBU:  w_wd = w_diff;
               OP_SLT:   w_wd = {31'd0, $signed(w_a) < $signed(w_b)};
               OP_SLTIU: w_wd = {31'd0, w_a < w_b};
               default:  w_wd = '0;
            endcase
         (ex.exe_alutype_i == ALUTYPE_LOGIC):
            case (w_op)
               OP_AND:  w_wd = w_a & w_b;
               OP_ORI:  w_wd = w_a | w_b;
               OP_LUI:  w_wd = w_b;
               default: w_wd = '0;
            endcase
         (ex.exe_alutype_i == ALUTYPE_MOVE):
            case (w_op)
               OP_MFHI: w_wd = w_hi;
               OP_MFLO: w_wd = w_lo;
               default: w_wd = '0;
            endcase
         (ex.exe_alutype_i == ALUTYPE_SHIFT):
            if (w_op == OP_SLL) w_wd = w_b << w_a[4:0];
         (ex.exe_alutype_i == ALUTYPE_JUMP):
            if (w_op == OP_JAL) w_wd = ex.exe_ret_addr_i;
         default: w_wd = '0;
      endcase
   end

`ifdef EXE_DIV_EN
   logic        w_done;
   logic [31:0] w_quo, w_rem;

   div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
      .clk        (cpu_clk),
      .rst_n      (rst_n),
      .i_start    (w_is_div),
      .i_flush    (flush),
      .i_hold     (exe_hold),
      .i_dividend (w_a),
      .i_divisor  (w_b),
      .o_busy     (w_busy),
      .o_done     (w_done),
      .o_quo      (w_quo),
      .o_rem      (w_rem)
   );

   assign w_div_hilo = w_done ? {w_rem, w_quo} : '0;
`else
   logic w_unused;

   assign w_busy     = 1'b0;
   assign w_div_hilo = '0;
   assign w_unused   = ^{cpu_clk, exe_hold, flush, 32'(DIV_CYCLES)};
`endif

   always_comb begin
      w_hilo = '0;
      if (w_is_mult)     w_hilo = w_prod;
      else if (w_is_div) w_hilo = w_div_hilo;
   end

   assign w_wreg = ex.exe_wreg_i && !w_exc_ov;

   assign ex.exe_wd_o       = rst_n ? w_wd : '0;
   assign ex.exe_hilo_o     = rst_n ? w_hilo : '0;
   assign ex.exe_wa_o       = rst_n ? ex.exe_wa_i : '0;
   assign ex.exe_wreg_o     = rst_n && w_wreg;
   assign ex.exe_mreg_o     = rst_n && ex.exe_mreg_i;
   assign ex.exe_whilo_o    = rst_n && ex.exe_whilo_i;
   assign ex.exe_din_o      = rst_n ? ex.exe_din_i : '0;
   assign ex.exe_aluop_o    = rst_n ? w_op : '0;
   assign ex.exe_pc_o       = rst_n ? ex.exe_pc_i : '0;
   assign ex.exe_in_delay_o = rst_n && ex.exe_in_delay_i;
   assign ex.exe_exccode_o  = !rst_n   ? EXC_NONE :
                              w_exc_ov ? EXC_OV : ex.exe_exccode_i;

   assign exe2id_wreg  = rst_n && w_wreg;
   assign exe2id_wa    = rst_n ? ex.exe_wa_i : '0;
   assign exe2id_wd    = rst_n ? w_wd : '0;
   assign exe2id_mreg  = rst_n && ex.exe_mreg_i;
   assign stallreq_exe = rst_n && w_busy;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, HI/LO forwarding, divider timing.
module tb_exe_stage;
   import mips_defs_pkg::*;

   logic        cpu_clk = 1'b0;
   logic        rst_n;
   logic [31:0] hi_i, lo_i;
   logic        mem2exe_whilo, wb2exe_whilo;
   logic [63:0] mem2exe_hilo, wb2exe_hilo;
   logic        exe_hold, flush;
   logic        exe2id_wreg, exe2id_mreg, stallreq_exe;
   logic [4:0]  exe2id_wa;
   logic [31:0] exe2id_wd;
   int          nerr = 0;
   int          nchk = 0;
   int          ncyc;
   int          exp_long, exp_short;
   logic [63:0] exp_m7d2, exp_9d0, exp_100d3;

   exe_stage_if ex();

   exe_stage dut (
      .cpu_clk       (cpu_clk),
      .rst_n         (rst_n),
      .ex            (ex),
      .hi_i          (hi_i),
      .lo_i          (lo_i),
      .mem2exe_whilo (mem2exe_whilo),
      .mem2exe_hilo  (mem2exe_hilo),
      .wb2exe_whilo  (wb2exe_whilo),
      .wb2exe_hilo   (wb2exe_hilo),
      .exe_hold      (exe_hold),
      .flush         (flush),
      .exe2id_wreg   (exe2id_wreg),
      .exe2id_wa     (exe2id_wa),
      .exe2id_wd     (exe2id_wd),
      .exe2id_mreg   (exe2id_mreg),
      .stallreq_exe  (stallreq_exe)
   );

   always #5 cpu_clk = ~cpu_clk;
   assign exe_hold = stallreq_exe;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      ex.exe_alutype_i = t;
      ex.exe_aluop_i   = op;
      ex.exe_src1_i    = a;
      ex.exe_src2_i    = b;
      #1;
   endtask

   task automatic run_div(output int n);
      n = 0;
      for (int c = 0; c < 200; c++) begin
         if (!stallreq_exe) break;
         n++;
         @(posedge cpu_clk);
         #1;
      end
   endtask

   task automatic step;
      @(posedge cpu_clk);
      #1;
   endtask

   initial begin
`ifdef EXE_DIV_EN
      exp_long  = 33;
      exp_short = 1;
      exp_m7d2  = {32'hFFFFFFFF, 32'hFFFFFFFD};
      exp_9d0   = {32'h00000009, 32'hFFFFFFFF};
      exp_100d3 = {32'h00000001, 32'h00000021};
`else
      exp_long  = 0;
      exp_short = 0;
      exp_m7d2  = '0;
      exp_9d0   = '0;
      exp_100d3 = '0;
`endif
      rst_n = 1'b0;
      flush = 1'b0;
      hi_i = 32'h11111111;
      lo_i = 32'h22222222;
      mem2exe_whilo = 1'b0;
      wb2exe_whilo  = 1'b0;
      mem2exe_hilo  = '0;
      wb2exe_hilo   = '0;
      ex.exe_wa_i       = 5'h1F;
      ex.exe_wreg_i     = 1'b1;
      ex.exe_mreg_i     = 1'b1;
      ex.exe_whilo_i    = 1'b1;
      ex.exe_din_i      = 32'hDEADBEEF;
      ex.exe_ret_addr_i = 32'h00400008;
      ex.exe_pc_i       = 32'h00400000;
      ex.exe_in_delay_i = 1'b1;
      ex.exe_exccode_i  = EXC_NONE;

      // outputs forced quiet while reset is held
      issue(ALUTYPE_MULDIV, OP_MULT, 32'hFFFFFFFE, 32'd3);
      step();
      chk("rst_hilo", ex.exe_hilo_o, 64'd0);
      chk("rst_exc", {59'd0, ex.exe_exccode_o}, {59'd0, EXC_NONE});
      chk("rst_wa", {59'd0, ex.exe_wa_o}, 64'd0);
      chk("rst_wreg", {63'd0, exe2id_wreg}, 64'd0);
      issue(ALUTYPE_MULDIV, OP_DIV, 32'd9, 32'd3);
      chk("rst_stall", {63'd0, stallreq_exe}, 64'd0);
      issue(ALUTYPE_ARITH, OP_ADD, 32'd1, 32'd2);
      chk("rst_wd", {32'd0, ex.exe_wd_o}, 64'd0);
      step();
      rst_n = 1'b1;
      #1;

      issue(ALUTYPE_ARITH, OP_ADD, 32'h7FFFFFFF, 32'h00000001);
      chk("add_wd", {32'd0, ex.exe_wd_o}, 64'h80000000);
      chk("add_exc", {59'd0, ex.exe_exccode_o}, {59'd0, EXC_OV});
      chk("add_wreg", {63'd0, ex.exe_wreg_o}, 64'd0);
      chk("add_fwd_wreg", {63'd0, exe2id_wreg}, 64'd0);
      ex.exe_exccode_i = EXC_SYS;
      #1;
      chk("add_exc_prio", {59'd0, ex.exe_exccode_o}, {59'd0, EXC_SYS});
      chk("add_prio_wreg", {63'd0, ex.exe_wreg_o}, 64'd1);
      ex.exe_exccode_i = EXC_NONE;
      issue(ALUTYPE_ARITH, OP_ADDIU, 32'h7FFFFFFF, 32'h00000001);
      chk("addiu_exc", {59'd0, ex.exe_exccode_o}, {59'd0, EXC_NONE});
      chk("addiu_wreg", {63'd0, ex.exe_wreg_o}, 64'd1);
      chk("addiu_fwd_wd", {32'd0, exe2id_wd}, 64'h80000000);
      chk("pass_wa", {59'd0, exe2id_wa}, 64'h1F);
      chk("pass_din", {32'd0, ex.exe_din_o}, 64'hDEADBEEF);
      chk("pass_pc", {32'd0, ex.exe_pc_o}, 64'h00400000);
      chk("pass_op", {56'd0, ex.exe_aluop_o}, 64'h19);

      issue(ALUTYPE_ARITH, OP_SLT, 32'hFFFFFFFF, 32'h00000001);
      chk("slt", {32'd0, ex.exe_wd_o}, 64'd1);
      issue(ALUTYPE_ARITH, OP_SLTIU, 32'hFFFFFFFF, 32'h00000001);
      chk("sltiu", {32'd0, ex.exe_wd_o}, 64'd0);
      issue(ALUTYPE_ARITH, OP_SUBU, 32'd5, 32'd7);
      chk("subu", {32'd0, ex.exe_wd_o}, 64'hFFFFFFFE);
      issue(ALUTYPE_ARITH, OP_LW, 32'h00001000, 32'hFFFFFFFC);
      chk("lw_addr", {32'd0, ex.exe_wd_o}, 64'h00000FFC);
      issue(ALUTYPE_LOGIC, OP_AND, 32'hF0F01234, 32'h0FF0FFFF);
      chk("and", {32'd0, ex.exe_wd_o}, 64'h00F01234);
      issue(ALUTYPE_LOGIC, OP_ORI, 32'h12340000, 32'h00005678);
      chk("ori", {32'd0, ex.exe_wd_o}, 64'h12345678);
      issue(ALUTYPE_LOGIC, OP_LUI, 32'h0, 32'hABCD0000);
      chk("lui", {32'd0, ex.exe_wd_o}, 64'hABCD0000);
      issue(ALUTYPE_SHIFT, OP_SLL, 32'h00000024, 32'h0000000F);
      chk("sll", {32'd0, ex.exe_wd_o}, 64'h000000F0);
      issue(ALUTYPE_JUMP, OP_JAL, 32'h0, 32'h0);
      chk("jal", {32'd0, ex.exe_wd_o}, 64'h00400008);
      issue(ALUTYPE_JUMP, OP_J, 32'h5, 32'h6);
      chk("j_wd", {32'd0, ex.exe_wd_o}, 64'd0);

      issue(ALUTYPE_MULDIV, OP_MULT, 32'hFFFFFFFE, 32'd3);
      chk("mult", ex.exe_hilo_o, 64'hFFFFFFFF_FFFFFFFA);
      chk("mult_whilo", {63'd0, ex.exe_whilo_o}, 64'd1);
      chk("mult_wd", {32'd0, ex.exe_wd_o}, 64'd0);

      mem2exe_whilo = 1'b1;
      mem2exe_hilo  = 64'hAAAA5555_0000BEEF;
      wb2exe_whilo  = 1'b1;
      wb2exe_hilo   = 64'h12345678_9ABCDEF0;
      issue(ALUTYPE_MOVE, OP_MFHI, 32'h0, 32'h0);
      chk("mfhi_mem", {32'd0, ex.exe_wd_o}, 64'hAAAA5555);
      mem2exe_whilo = 1'b0;
      issue(ALUTYPE_MOVE, OP_MFLO, 32'h0, 32'h0);
      chk("mflo_wb", {32'd0, ex.exe_wd_o}, 64'h9ABCDEF0);
      wb2exe_whilo = 1'b0;
      issue(ALUTYPE_MOVE, OP_MFHI, 32'h0, 32'h0);
      chk("mfhi_arch", {32'd0, ex.exe_wd_o}, 64'h11111111);

      issue(ALUTYPE_MULDIV, OP_DIV, 32'hFFFFFFF9, 32'd2);
      run_div(ncyc);
      chk("div_stall_cycles", 64'(ncyc), 64'(exp_long));
      chk("div_hilo", ex.exe_hilo_o, exp_m7d2);
      chk("div_wd", {32'd0, ex.exe_wd_o}, 64'd0);
      issue(ALUTYPE_JUMP, OP_J, 32'h0, 32'h0);
      step();

      issue(ALUTYPE_MULDIV, OP_DIV, 32'd9, 32'd0);
      run_div(ncyc);
      chk("div0_stall_cycles", 64'(ncyc), 64'(exp_short));
      chk("div0_hilo", ex.exe_hilo_o, exp_9d0);
      issue(ALUTYPE_JUMP, OP_J, 32'h0, 32'h0);
      step();

      issue(ALUTYPE_MULDIV, OP_DIV, 32'd100, 32'd3);
      for (int c = 0; c < 10; c++) step();
      flush = 1'b1;
      #1;
      chk("flush_stall", {63'd0, stallreq_exe}, 64'd0);
      step();
      flush = 1'b0;
      issue(ALUTYPE_JUMP, OP_J, 32'h0, 32'h0);
      chk("post_flush_stall", {63'd0, stallreq_exe}, 64'd0);
      step();
      issue(ALUTYPE_MULDIV, OP_DIV, 32'd100, 32'd3);
      run_div(ncyc);
      chk("refire_cycles", 64'(ncyc), 64'(exp_long));
      chk("refire_hilo", ex.exe_hilo_o, exp_100d3);
      issue(ALUTYPE_JUMP, OP_J, 32'h0, 32'h0);
      step();

      // reset mid-divide must restart the divider from scratch
      issue(ALUTYPE_MULDIV, OP_DIV, 32'd100, 32'd3);
      for (int c = 0; c < 5; c++) step();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_stall", {63'd0, stallreq_exe}, 64'd0);
      step();
      rst_n = 1'b1;
      #1;
      run_div(ncyc);
      chk("rst_mid_cycles", 64'(ncyc), 64'(exp_long));
      chk("rst_mid_hilo", ex.exe_hilo_o, exp_100d3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage MIPS32 pipeline, directly downstream of the decode stage through the ID/EXE pipeline register. It consumes the decoded ALU type/opcode and source operands and computes the write-back value and the HI/LO value. It also produces the forwarding bundle fed back to decode. Signed division runs on an iterative multi-cycle divider that requests a pipeline stall while busy.

## Interface
- `DIV_CYCLES`, default 32: number of divider iteration cycles, one quotient bit per cycle.
- `cpu_clk  in  1`: stage clock.
- `rst_n  in  1`: asynchronous active-low reset.
- `exe_alutype_i  in  3`: 001 arith, 010 logic, 011 move, 100 shift, 101 jump/branch, 110 privileged, 000 mult/div.
- `exe_aluop_i  in  8`: opcode, encoded per `mips_defs_pkg`.
- `exe_src1_i`, `exe_src2_i  in  32`: operands, already forwarded and immediate-extended.
- `exe_wa_i  in  5`, `exe_wreg_i  in  1`, `exe_mreg_i  in  1`, `exe_whilo_i  in  1`, `exe_din_i  in  32`: passed through.
- `exe_ret_addr_i  in  32`: PC+8 for `jal`.
- `exe_pc_i  in  32`, `exe_in_delay_i  in  1`, `exe_exccode_i  in  5`: exception context.
- `hi_i`, `lo_i  in  32`: architectural HI/LO.
- `mem2exe_whilo  in  1`, `mem2exe_hilo  in  64`, `wb2exe_whilo  in  1`, `wb2exe_hilo  in  64`: HI/LO forwarding.
- `exe_hold  in  1`: the EXE instruction stays in EXE next cycle.
- `flush  in  1`: exception flush.
- `exe_wd_o  out  32`, `exe_hilo_o  out  64`, and the pass-through outputs `exe_wa_o`, `exe_wreg_o`, `exe_mreg_o`, `exe_whilo_o`, `exe_din_o`, `exe_aluop_o`, `exe_pc_o`, `exe_in_delay_o`, `exe_exccode_o`.
- `exe2id_wreg  out  1`, `exe2id_wa  out  5`, `exe2id_wd  out  32`, `exe2id_mreg  out  1`: forwarding to decode.
- `stallreq_exe  out  1`: divider busy.

## Operation
- Opcodes: ADD 0x18, ADDIU 0x19, SUBU 0x1B, SLT 0x26, SLTIU 0x27, AND 0x1C, ORI 0x1D, LUI 0x05, SLL 0x11, MFHI 0x0C, MFLO 0x0D, MULT 0x14, DIV 0x16, J 0x2C, JR 0x2D, JAL 0x2E, loads and stores 0x90/0x92/0x98/0x9A.
- Arith:
  - ADD, ADDIU, loads and stores: src1+src2, mod 2^32.
  - SUBU: src1−src2.
  - SLT: signed compare, result 0 or 1.
  - SLTIU: unsigned compare, result 0 or 1.
- ADD overflow (both operand signs equal, result sign differs): `exe_exccode_o`=0x0C and `exe_wreg_o`=0. This applies only if the incoming code is 0x10; an earlier exception code wins.
- Logic: AND→src1&src2; ORI→src1|src2; LUI→src2.
- Shift: SLL→src2<<src1[4:0].
- Move: the HI/LO source is chosen by priority mem > wb > `hi_i`/`lo_i`. MFHI returns HI, MFLO returns LO.
- JAL: result is `exe_ret_addr_i`.
- MULT: signed 64-bit product, combinational, to `exe_hilo_o` as {HI,LO}.
- DIV: signed; HI=remainder (sign of dividend), LO=quotient truncated toward zero.
- Divide by zero: LO=0xFFFFFFFF, HI=dividend. Resolves without iterating.
- Divider FSM:
  - IDLE: DIV present and no `flush` → BUSY, magnitudes loaded, counter=0.
  - BUSY: one restoring step per cycle. After counter=`DIV_CYCLES`−1 → DONE.
  - DONE: signs fixed and result held. `exe_hold`=1 → stay in DONE; otherwise → IDLE.
  - Divide by zero: IDLE → DONE directly.
- `stallreq_exe`=1 when DIV is present and state≠DONE, combinationally and including the first IDLE cycle.
- `flush` in any state → IDLE next edge, result discarded, `stallreq_exe`=0 that cycle.
- `exe2id_*` mirror `exe_wreg_o`, `exe_wa_o`, `exe_wd_o`, `exe_mreg_o`.
- `exe_wd_o`=0 for opcodes with no GPR result.

## Timing
- Reset and `rst_n` low: every output 0 except `exe_exccode_o`=0x10. FSM in IDLE, counter 0, divider registers 0.
- All non-divide results are combinational, with zero cycles of latency.
- DIV issued in cycle 0 (IDLE): `stallreq_exe` is high for cycles 0…`DIV_CYCLES`. In cycle `DIV_CYCLES`+1 the FSM is in DONE, `stallreq_exe`=0, and `exe_hilo_o` is valid.
- Reset asserted mid-divide: immediate IDLE.

## Configuration
- `EXE_DIV_EN` defined: the iterative divider and FSM are compiled in.
- `EXE_DIV_EN` undefined:
  - the divider and FSM are removed;
  - DIV yields `exe_hilo_o`=0 with `exe_whilo_o` still passed through;
  - `stallreq_exe` is tied to 0.

## Structure
- `mips_defs_pkg` holds:
  - the ALUTYPE and ALUOP localparams;
  - the exception codes EXC_NONE 0x10, EXC_SYS 0x08, EXC_OV 0x0C, EXC_ERET 0x11;
  - the divider state enum.
- Sub-module `div_iter` (clock, reset, start, flush, hold, signed operands, busy, done, quotient, remainder) contains the FSM. `exe_stage` holds the ALU, the HI/LO forwarding mux, and the exception merge.

## Test plan
- ADD 0x7FFFFFFF+0x00000001 → `exe_wd_o`=0x80000000, `exe_exccode_o`=0x0C, `exe_wreg_o`=0. ADDIU with the same operands → no exception, `exe_wreg_o`=1.
- SLT 0xFFFFFFFF vs 0x00000001 → 1. SLTIU with the same operands → 0. SUBU 5−7 → 0xFFFFFFFE.
- MULT −2×3 → `exe_hilo_o`=0xFFFFFFFF_FFFFFFFA, with `exe_whilo_o` passed through.
- DIV −7/2 with `exe_hold` following `stallreq_exe`:
  - `stallreq_exe` high for exactly 33 cycles;
  - then `exe_hilo_o`={0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 9/0 → one stall cycle, then `exe_hilo_o`={0x00000009, 0xFFFFFFFF}.
- MFHI with `mem2exe_whilo`=1 (HI=0xAAAA5555) and `wb2exe_whilo`=1 → `exe_wd_o`=0xAAAA5555.
- `flush` in cycle 10 of a DIV → IDLE next cycle and `stallreq_exe`=0.
